// File: rtl/cpu_reg_dump.sv
// Snapshots CPU registers on request and streams them out over a valid/ready byte port.
// Define REG_DUMP_HEX_EN for a 16-byte ASCII hex stream (with CR LF) instead of the 7 raw bytes.
module cpu_reg_dump (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dump_req,
    input  logic [7:0]  reg_a,
    input  logic [7:0]  reg_x,
    input  logic [7:0]  reg_y,
    input  logic [7:0]  reg_sp,
    input  logic [7:0]  reg_p,
    input  logic [15:0] reg_pc,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

`ifdef REG_DUMP_HEX_EN
    localparam logic [3:0] LAST_IDX = 4'd15;
`else
    localparam logic [3:0] LAST_IDX = 4'd6;
`endif

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t      state_q, state_d;
    logic [55:0] snap_q, snap_d;
    logic [55:0] live;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Snapshot is packed in stream order so byte k of the raw stream is the k-th byte from the MSB.
    function automatic logic [7:0] byte_at(input logic [55:0] raw, input logic [3:0] idx);
        logic [7:0] res;
`ifdef REG_DUMP_HEX_EN
        logic [3:0] nib;
        nib = 4'h0;
        if (idx == 4'd14) begin
            res = 8'h0D;
        end else if (idx == 4'd15) begin
            res = 8'h0A;
        end else begin
            nib = raw[55 - 4 * 32'(idx) -: 4];
            res = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end
`else
        res = raw[55 - 8 * 32'(idx) -: 8];
`endif
        return res;
    endfunction

    assign live = {reg_a, reg_x, reg_y, reg_sp, reg_pc, reg_p};

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    // First byte comes straight from the live inputs so it is valid the cycle after capture.
                    snap_d     = live;
                    idx_d      = '0;
                    tx_data_d  = byte_at(live, 4'd0);
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        tx_data_d  = '0;
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = byte_at(snap_q, idx_q + 4'd1);
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                tx_data_d  = '0;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_cpu_reg_dump.sv
// Self-checking bench for cpu_reg_dump: directed literal cases plus randomized traffic
// compared every cycle against a queue-based model of the byte stream.
module tb_cpu_reg_dump;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dump_req = 1'b0;
    logic [7:0]  reg_a = '0, reg_x = '0, reg_y = '0, reg_sp = '0, reg_p = '0;
    logic [15:0] reg_pc = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    cpu_reg_dump dut (
        .clk(clk), .rst_n(rst_n), .dump_req(dump_req),
        .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp),
        .reg_p(reg_p), .reg_pc(reg_pc),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef REG_DUMP_HEX_EN
    localparam int LEN    = 16;
    localparam int X_IDX  = 2;
    localparam int SP_IDX = 6;
    localparam logic [7:0] STALL_EXP = 8'h30;
    localparam logic [7:0] EXP_LIT [16] = '{8'h41, 8'h42, 8'h30, 8'h31, 8'h30, 8'h30, 8'h46, 8'h44,
                                            8'h43, 8'h30, 8'h44, 8'h45, 8'h32, 8'h34, 8'h0D, 8'h0A};
`else
    localparam int LEN    = 7;
    localparam int X_IDX  = 1;
    localparam int SP_IDX = 3;
    localparam logic [7:0] STALL_EXP = 8'h34;
    localparam logic [7:0] EXP_LIT [16] = '{8'h12, 8'h34, 8'h56, 8'hFF, 8'h02, 8'h00, 8'h20, 8'h00,
                                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: expected stream as a byte queue ----------------
    logic [7:0] m_q[$];
    int         m_phase = 0;   // 0 waiting, 1 streaming, 2 finishing
    logic [7:0] m_data  = '0;
    logic       m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;

    task automatic build_stream();
        logic [7:0] raw[$];
        string s;
        raw = '{reg_a, reg_x, reg_y, reg_sp, reg_pc[15:8], reg_pc[7:0], reg_p};
        m_q.delete();
`ifdef REG_DUMP_HEX_EN
        foreach (raw[i]) begin
            s = $sformatf("%02X", raw[i]);
            m_q.push_back(s[0]);
            m_q.push_back(s[1]);
        end
        m_q.push_back(8'h0D);
        m_q.push_back(8'h0A);
`else
        foreach (raw[i]) m_q.push_back(raw[i]);
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_valid = 1'b0; m_data = '0; m_busy = 1'b0; m_done = 1'b0;
            m_q.delete();
        end else if (m_phase == 0) begin
            if (dump_req) begin
                build_stream();
                m_phase = 1; m_valid = 1'b1; m_busy = 1'b1; m_data = m_q[0];
            end
        end else if (m_phase == 1) begin
            if (tx_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_phase = 2; m_valid = 1'b0; m_data = '0; m_done = 1'b1;
                end else begin
                    m_data = m_q[0];
                end
            end
        end else begin
            m_phase = 0; m_done = 1'b0; m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid", {31'b0, tx_valid}, {31'b0, m_valid});
        chk("cyc_data",  {24'b0, tx_data},  {24'b0, m_data});
        chk("cyc_busy",  {31'b0, busy},     {31'b0, m_busy});
        chk("cyc_done",  {31'b0, done},     {31'b0, m_done});
        if (done) done_cnt++;
        if (tx_valid && tx_ready) acc_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs();
`ifdef REG_DUMP_HEX_EN
        reg_a = 8'hAB; reg_x = 8'h01; reg_y = 8'h00; reg_sp = 8'hFD; reg_pc = 16'hC0DE; reg_p = 8'h24;
`else
        reg_a = 8'h12; reg_x = 8'h34; reg_y = 8'h56; reg_sp = 8'hFF; reg_pc = 16'h0200; reg_p = 8'h20;
`endif
    endtask

    task automatic start_dump();
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (!busy) begin ok = 1'b1; break; end
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        int d0, a0;
        // reset values
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rst_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_data",  {24'b0, tx_data},  32'd0);
        chk("rst_busy",  {31'b0, busy},     32'd0);
        chk("rst_done",  {31'b0, done},     32'd0);

        // back-to-back dump, literal bytes and timing
        set_regs();
        tx_ready = 1'b1;
        step();
        start_dump();
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            chk("b2b_valid", {31'b0, tx_valid}, 32'd1);
            chk("b2b_byte",  {24'b0, tx_data},  {24'b0, EXP_LIT[k]});
            step();
        end
        @(negedge clk);
        chk("b2b_done",     {31'b0, done},     32'd1);
        chk("b2b_busy_dn",  {31'b0, busy},     32'd1);
        chk("b2b_valid_dn", {31'b0, tx_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("b2b_done_off", {31'b0, done}, 32'd0);
        chk("b2b_busy_off", {31'b0, busy}, 32'd0);

        // backpressure on X byte with live reg_x changing
        step();
        a0 = acc_cnt;
        start_dump();
        reg_x = 8'h99;
        repeat (X_IDX) step();
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_data",  {24'b0, tx_data},  {24'b0, STALL_EXP});
            chk("stall_valid", {31'b0, tx_valid}, 32'd1);
            step();
        end
        tx_ready = 1'b1;
        wait_idle("stall_finish");
        chk("stall_count", acc_cnt - a0, LEN);
        set_regs();

        // request during SEND is ignored
        step();
        d0 = done_cnt;
        start_dump();
        step();
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        wait_idle("busyreq_finish");
        repeat (4) step();
        chk("busyreq_one_done", done_cnt - d0, 1);
        chk("busyreq_idle", {31'b0, busy}, 32'd0);

        // asynchronous reset while the SP byte is presented
        start_dump();
        repeat (SP_IDX) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, tx_valid}, 32'd0);
        chk("arst_busy",  {31'b0, busy},     32'd0);
        chk("arst_data",  {24'b0, tx_data},  32'd0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        start_dump();
        @(negedge clk);
        chk("arst_restart", {24'b0, tx_data}, {24'b0, EXP_LIT[0]});
        wait_idle("arst_finish");

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            dump_req = ($urandom_range(0, 7) == 0);
            tx_ready = ($urandom_range(0, 3) != 0);
            reg_a  = 8'($urandom); reg_x = 8'($urandom); reg_y = 8'($urandom);
            reg_sp = 8'($urandom); reg_p = 8'($urandom); reg_pc = 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step();
        end
        dump_req = 1'b0;
        tx_ready = 1'b1;
        wait_idle("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
